coin_accumulator: RTL and testbench
===================================

# coin_accumulator

Parametrised multi-channel coin accumulator for the ticket vending machine datapath. It arbitrates up to CH coin-acceptor channels round-robin and adds each accepted coin value into a running transaction total. The total saturates at a programmable cap with a sticky overflow flag. Each coin produces a one-cycle `out_rdy`/`data_out` report followed by a `state_cmp` completion pulse. A cancel request refunds the whole total in one pulse. It sits between the coin input stage and the price-compare/dispense stage.

## Interface
- `WIDTH`, 8: bit width of coin values, total and `data_out`; must be ≥2.
- `CH`, 4: number of coin channels, 1..8.
- `MAX_TOTAL`, 255: saturation cap for the total; must be ≤ 2^WIDTH−1.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; synchronous, active-low.
- `clr`  in  1  start new transaction: zero total and ovf; sampled in IDLE only.
- `cancel`  in  1  refund request; sampled in IDLE only.
- `in_rdy`  in  CH  per-channel coin-valid. Held, with its data, until that channel's `in_ack`.
- `data_in`  in  CH*WIDTH  packed coin values; channel k is `data_in[k*WIDTH +: WIDTH]`.
- `in_ack`  out  CH  registered one-hot grant, one cycle.
- `out_rdy`  out  1  total-report strobe, one cycle.
- `data_out`  out  WIDTH  total, valid with `out_rdy` or `refund`; 0 otherwise.
- `refund`  out  1  refund strobe, one cycle; `data_out` = refunded amount.
- `state_cmp`  out  1  operation-complete pulse, one cycle.
- `ovf`  out  1  sticky saturation flag.
- `busy`  out  1  high whenever state ≠ IDLE; decoded from the state register.

## Operation
- Reset (`rst`=0 at a rising edge) clears everything:
  - state=IDLE, total=0, round-robin pointer=0.
  - All outputs 0.
- States: IDLE, ADD, REPORT, DONE, REFUND.
- IDLE: drives `state_cmp`←0. Priority is `clr` > `cancel` > coin.
  - `clr`: total←0, ovf←0; stay in IDLE; no grant this cycle.
  - `cancel`: go to REFUND.
  - Any `in_rdy` set:
    - Grant g = first set bit searching upward from the pointer, wrapping CH−1→0.
    - Latch value←`data_in[g]`, `in_ack[g]`←1, pointer←(g+1) mod CH.
    - Go to ADD.
- ADD:
  - `in_ack`←0.
  - sum = total + value, computed in WIDTH+1 bits.
  - If sum > MAX_TOTAL: total←MAX_TOTAL, ovf←1. Else total←sum.
  - Go to REPORT.
- REPORT: `out_rdy`←1, `data_out`←total; go to DONE.
- REFUND:
  - `refund`←1, `data_out`←total.
  - total←0, ovf←0.
  - Go to DONE.
- DONE:
  - `out_rdy`←0, `refund`←0, `data_out`←0, `state_cmp`←1.
  - Go to IDLE.
- Zero-valued coins are accepted and reported normally.
- `clr`, `cancel` and `in_rdy` are ignored outside IDLE. Requesters must hold them.
- Refund with total=0 still produces `refund` with `data_out`=0.

## Timing
- Cycle numbering is relative to the IDLE cycle that samples the request (cycle 0).
- Coin path:
  - `in_ack` high in cycle 1.
  - Total updated at the end of cycle 1.
  - `out_rdy`=1 and `data_out`=new total in cycle 3.
  - `state_cmp`=1 in cycle 4, which is also IDLE.
  - The next request can be sampled in cycle 4, so throughput is one coin per 4 cycles.
- Refund path: `refund`=1 in cycle 2; `state_cmp`=1 in cycle 3. `out_rdy` stays 0.
- `clr` takes effect at the end of cycle 0; `busy` stays 0.
- A requester drops `in_rdy` or updates its data no later than the cycle after it sees `in_ack`.
- `rst` low in any state aborts the operation. All outputs are 0 in the following cycle, and no `state_cmp` is issued for the aborted operation.

## Test plan
- **Reset:** hold `rst`=0 for 2 cycles with random inputs → all outputs 0, `busy`=0; first coin afterwards is granted from channel 0.
- **Single coins:** ch1=25 → `in_ack`=0010 in cycle 1, `out_rdy`=1/`data_out`=25 in cycle 3, `state_cmp` in cycle 4. Then ch0=10 → `data_out`=35.
- **Round-robin:** `in_rdy`=1111 with values 5,10,20,50, each held until acked → grants in order ch0,1,2,3; reports 5,15,35,85. Re-raising ch0 and ch3 together after ch3 → ch0 is granted first (pointer wrapped).
- **Saturation** (MAX_TOTAL=200):
  - Total 190, add 50 → `data_out`=200, `ovf`=1.
  - Add 5 → 200, `ovf` stays 1.
  - `clr` → `ovf`=0; then add 5 → 5.
- **Refund:** total 85, `cancel` → `refund`=1 with `data_out`=85 in cycle 2 and `out_rdy`=0; `state_cmp` in cycle 3. Next coin of 10 → `data_out`=10.
- **Conflicts and abort:**
  - `clr`, `cancel` and `in_rdy`=0001 in the same IDLE cycle → total 0, no `in_ack`, no refund; the coin is granted on the next IDLE cycle.
  - `rst`=0 during REPORT → `out_rdy`=0, `data_out`=0 and total=0 the next cycle.

Source files
------------

// File: rtl/coin_accumulator.sv
// Multi-channel coin accumulator: round-robin grant, saturating running total,
// per-coin report/complete pulses and a single-pulse refund of the whole total.
module coin_accumulator #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CH        = 4,
    parameter int unsigned MAX_TOTAL = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  cancel,
    input  logic [CH-1:0]         in_rdy,
    input  logic [CH*WIDTH-1:0]   data_in,
    output logic [CH-1:0]         in_ack,
    output logic                  out_rdy,
    output logic [WIDTH-1:0]      data_out,
    output logic                  refund,
    output logic                  state_cmp,
    output logic                  ovf,
    output logic                  busy
);

    localparam int unsigned    PTR_W   = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [WIDTH:0] CAP_EXT = (WIDTH+1)'(MAX_TOTAL);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADD,
        S_REPORT,
        S_DONE,
        S_REFUND
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] total_q, total_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             ovf_q, ovf_d;
    logic [CH-1:0]    in_ack_q, in_ack_d;
    logic             out_rdy_q, out_rdy_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             refund_q, refund_d;
    logic             state_cmp_q, state_cmp_d;

    logic             grant_vld;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W:0]   cand;
    logic [WIDTH:0]   sum;

    // Round-robin search: first requester at or above the pointer, wrapping.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            cand = {1'b0, ptr_q} + (PTR_W+1)'(i);
            if (cand >= (PTR_W+1)'(CH)) begin
                cand = cand - (PTR_W+1)'(CH);
            end
            if (!grant_vld && in_rdy[cand[PTR_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[PTR_W-1:0];
            end
        end
    end

    assign sum = {1'b0, total_q} + {1'b0, value_q};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (clr) begin
                    state_d = S_IDLE;
                end else if (cancel) begin
                    state_d = S_REFUND;
                end else if (grant_vld) begin
                    state_d = S_ADD;
                end
            end
            S_ADD:    state_d = S_REPORT;
            S_REPORT: state_d = S_DONE;
            S_REFUND: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Strobes default low each cycle, so every reported value is a one-cycle pulse.
    always_comb begin
        total_d     = total_q;
        value_d     = value_q;
        ptr_d       = ptr_q;
        ovf_d       = ovf_q;
        in_ack_d    = '0;
        out_rdy_d   = 1'b0;
        data_out_d  = '0;
        refund_d    = 1'b0;
        state_cmp_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (clr) begin
                    total_d = '0;
                    ovf_d   = 1'b0;
                end else if (!cancel && grant_vld) begin
                    value_d             = data_in[32'(grant_idx)*WIDTH +: WIDTH];
                    in_ack_d[grant_idx] = 1'b1;
                    if (grant_idx == PTR_W'(CH-1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = grant_idx + PTR_W'(1);
                    end
                end
            end
            S_ADD: begin
                if (sum > CAP_EXT) begin
                    total_d = WIDTH'(MAX_TOTAL);
                    ovf_d   = 1'b1;
                end else begin
                    total_d = sum[WIDTH-1:0];
                end
            end
            S_REPORT: begin
                out_rdy_d  = 1'b1;
                data_out_d = total_q;
            end
            S_REFUND: begin
                refund_d   = 1'b1;
                data_out_d = total_q;
                total_d    = '0;
                ovf_d      = 1'b0;
            end
            S_DONE: begin
                state_cmp_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            total_q     <= '0;
            value_q     <= '0;
            ptr_q       <= '0;
            ovf_q       <= 1'b0;
            in_ack_q    <= '0;
            out_rdy_q   <= 1'b0;
            data_out_q  <= '0;
            refund_q    <= 1'b0;
            state_cmp_q <= 1'b0;
        end else begin
            total_q     <= total_d;
            value_q     <= value_d;
            ptr_q       <= ptr_d;
            ovf_q       <= ovf_d;
            in_ack_q    <= in_ack_d;
            out_rdy_q   <= out_rdy_d;
            data_out_q  <= data_out_d;
            refund_q    <= refund_d;
            state_cmp_q <= state_cmp_d;
        end
    end

    assign in_ack    = in_ack_q;
    assign out_rdy   = out_rdy_q;
    assign data_out  = data_out_q;
    assign refund    = refund_q;
    assign state_cmp = state_cmp_q;
    assign ovf       = ovf_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_coin_accumulator.sv
// Scoreboard bench for coin_accumulator (WIDTH=8, CH=4, MAX_TOTAL=200).
module tb_coin_accumulator;

    localparam int W    = 8;
    localparam int NCH  = 4;
    localparam int MAXT = 200;

    logic           clk = 1'b0;
    logic           rst;
    logic           clr;
    logic           cancel;
    logic [NCH-1:0] in_rdy;
    logic [NCH*W-1:0] data_in;
    logic [NCH-1:0] in_ack;
    logic           out_rdy;
    logic [W-1:0]   data_out;
    logic           refund;
    logic           state_cmp;
    logic           ovf;
    logic           busy;

    coin_accumulator #(.WIDTH(W), .CH(NCH), .MAX_TOTAL(MAXT)) dut (
        .clk(clk), .rst(rst), .clr(clr), .cancel(cancel), .in_rdy(in_rdy),
        .data_in(data_in), .in_ack(in_ack), .out_rdy(out_rdy), .data_out(data_out),
        .refund(refund), .state_cmp(state_cmp), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_refund;
        logic [W-1:0] val;
        bit         ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_total  = 0;
    bit   m_ovf    = 1'b0;

    function automatic void model_clear();
        m_total = 0;
        m_ovf   = 1'b0;
    endfunction

    function automatic void push_coin(input int val);
        exp_t e;
        int   s;
        s = m_total + val;
        if (s > MAXT) begin
            m_total = MAXT;
            m_ovf   = 1'b1;
        end else begin
            m_total = s;
        end
        e.is_refund = 1'b0;
        e.val       = W'(m_total);
        e.ovf       = m_ovf;
        exp_q.push_back(e);
    endfunction

    function automatic void push_refund();
        exp_t e;
        e.is_refund = 1'b1;
        e.val       = W'(m_total);
        e.ovf       = 1'b0;
        exp_q.push_back(e);
        model_clear();
    endfunction

    task automatic set_ch(input int ch, input int val);
        in_rdy[ch]          = 1'b1;
        data_in[ch*W +: W]  = W'(val);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0; clr = 1'b0; cancel = 1'b0; in_rdy = '0; data_in = '0;
        step();
        rst = 1'b1;
        model_clear();
        exp_q.delete();
    endtask

    // Runs one operation from the current IDLE cycle (cycle 0) and records when events occur.
    task automatic run_op(output logic [NCH-1:0] ack_v, output int ack_c,
                          output logic [W-1:0] rpt_v, output int rpt_c, output bit rpt_ovf,
                          output logic [W-1:0] ref_v, output int ref_c,
                          output int cmp_c, output bit leak);
        ack_v = '0; ack_c = -1; rpt_v = '0; rpt_c = -1; rpt_ovf = 1'b0;
        ref_v = '0; ref_c = -1; cmp_c = -1; leak = 1'b0;
        for (int cyc = 1; cyc <= 12 && cmp_c < 0; cyc++) begin
            step();
            clr = 1'b0;
            cancel = 1'b0;
            if (in_ack !== '0 && ack_c < 0) begin
                ack_v  = in_ack;
                ack_c  = cyc;
                in_rdy = in_rdy & ~in_ack;
            end
            if (out_rdy === 1'b1 && rpt_c < 0) begin
                rpt_v = data_out; rpt_c = cyc; rpt_ovf = ovf;
            end
            if (refund === 1'b1 && ref_c < 0) begin
                ref_v = data_out; ref_c = cyc;
            end
            if (out_rdy !== 1'b1 && refund !== 1'b1 && data_out !== '0) leak = 1'b1;
            if (state_cmp === 1'b1) cmp_c = cyc;
        end
    endtask

    logic [NCH-1:0] ack_v;
    int             ack_c, rpt_c, ref_c, cmp_c;
    logic [W-1:0]   rpt_v, ref_v;
    bit             rpt_ovf, leak;

    task automatic test_reset();
        exp_t e;
        int   v0;
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            clr = 1'($urandom_range(0, 1)); cancel = 1'($urandom_range(0, 1));
            in_rdy = NCH'($urandom); data_in = (NCH*W)'($urandom);
            step();
            n_checks++;
            if ({in_ack, out_rdy, data_out, refund, state_cmp, ovf, busy} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs c%0d: got ack=%b rdy=%b dout=%0d ref=%b cmp=%b ovf=%b busy=%b, expected all 0",
                         c, in_ack, out_rdy, data_out, refund, state_cmp, ovf, busy);
            end
        end
        rst = 1'b1; clr = 1'b0; cancel = 1'b0; in_rdy = '0; data_in = '0;
        model_clear();
        v0 = int'($urandom_range(1, 50));
        set_ch(0, v0);
        set_ch(3, 77);
        push_coin(v0);
        run_op(ack_v, ack_c, rpt_v, rpt_c, rpt_ovf, ref_v, ref_c, cmp_c, leak);
        in_rdy = '0;
        n_checks++;
        if (ack_v !== 4'b0001 || ack_c !== 1) begin
            n_fail++; $display("FAIL reset_first_grant: got ack=%b@%0d expected 0001@1", ack_v, ack_c);
        end
        e = exp_q.pop_front();
        n_checks++;
        if (rpt_v !== e.val || rpt_c !== 3 || cmp_c !== 4) begin
            n_fail++; $display("FAIL reset_first_report: got %0d@%0d cmp@%0d expected %0d@3 cmp@4", rpt_v, rpt_c, cmp_c, e.val);
        end
    endtask

    task automatic test_single();
        int   chs[2]  = '{1, 0};
        int   vals[2] = '{25, 10};
        exp_t e;
        clr = 1'b1;
        step();
        clr = 1'b0;
        model_clear();
        n_checks++;
        if (busy !== 1'b0 || ovf !== 1'b0) begin
            n_fail++; $display("FAIL clr_idle: got busy=%b ovf=%b expected 0 0", busy, ovf);
        end
        for (int k = 0; k < 2; k++) begin
            set_ch(chs[k], vals[k]);
            push_coin(vals[k]);
            run_op(ack_v, ack_c, rpt_v, rpt_c, rpt_ovf, ref_v, ref_c, cmp_c, leak);
            e = exp_q.pop_front();
            n_checks++;
            if (ack_v !== NCH'(1 << chs[k]) || ack_c !== 1) begin
                n_fail++; $display("FAIL single_ack%0d: got %b@%0d expected %b@1", k, ack_v, ack_c, NCH'(1 << chs[k]));
            end
            n_checks++;
            if (rpt_v !== e.val || rpt_c !== 3) begin
                n_fail++; $display("FAIL single_report%0d: got %0d@%0d expected %0d@3", k, rpt_v, rpt_c, e.val);
            end
            n_checks++;
            if (cmp_c !== 4 || leak || ref_c !== -1) begin
                n_fail++; $display("FAIL single_cmp%0d: got cmp@%0d leak=%b ref@%0d expected cmp@4 leak=0 ref@-1", k, cmp_c, leak, ref_c);
            end
        end
    endtask

    task automatic test_round_robin();
        int             vals[4] = '{5, 10, 20, 50};
        logic [NCH-1:0] acks[6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b1000};
        exp_t           e;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_ch(k, vals[k]);
            push_coin(vals[k]);
        end
        for (int k = 0; k < 6; k++) begin
            if (k == 4) begin
                set_ch(0, 0);
                set_ch(3, 0);
                push_coin(0);
                push_coin(0);
            end
            run_op(ack_v, ack_c, rpt_v, rpt_c, rpt_ovf, ref_v, ref_c, cmp_c, leak);
            e = exp_q.pop_front();
            n_checks++;
            if (ack_v !== acks[k] || ack_c !== 1) begin
                n_fail++; $display("FAIL rr_grant%0d: got %b@%0d expected %b@1", k, ack_v, ack_c, acks[k]);
            end
            n_checks++;
            if (rpt_v !== e.val || rpt_c !== 3 || cmp_c !== 4) begin
                n_fail++; $display("FAIL rr_report%0d: got %0d@%0d cmp@%0d expected %0d@3 cmp@4", k, rpt_v, rpt_c, cmp_c, e.val);
            end
        end
    endtask

    task automatic test_refund();
        exp_t e;
        cancel = 1'b1;
        push_refund();
        run_op(ack_v, ack_c, rpt_v, rpt_c, rpt_ovf, ref_v, ref_c, cmp_c, leak);
        e = exp_q.pop_front();
        n_checks++;
        if (!e.is_refund || ref_v !== e.val || ref_c !== 2) begin
            n_fail++; $display("FAIL refund_value: got %0d@%0d expected %0d@2", ref_v, ref_c, e.val);
        end
        n_checks++;
        if (rpt_c !== -1 || ack_c !== -1 || cmp_c !== 3 || leak) begin
            n_fail++; $display("FAIL refund_seq: got rdy@%0d ack@%0d cmp@%0d leak=%b expected -1 -1 3 0", rpt_c, ack_c, cmp_c, leak);
        end
        set_ch(2, 10);
        push_coin(10);
        run_op(ack_v, ack_c, rpt_v, rpt_c, rpt_ovf, ref_v, ref_c, cmp_c, leak);
        e = exp_q.pop_front();
        n_checks++;
        if (ack_v !== 4'b0100 || rpt_v !== e.val || rpt_c !== 3) begin
            n_fail++; $display("FAIL refund_next_coin: got ack=%b %0d@%0d expected 0100 %0d@3", ack_v, rpt_v, rpt_c, e.val);
        end
    endtask

    task automatic test_saturation();
        int   chs[4]  = '{1, 2, 3, 0};
        int   vals[4] = '{190, 50, 5, 5};
        exp_t e;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                clr = 1'b1;
                step();
                clr = 1'b0;
                model_clear();
                n_checks++;
                if (ovf !== 1'b0 || busy !== 1'b0) begin
                    n_fail++; $display("FAIL sat_clr: got ovf=%b busy=%b expected 0 0", ovf, busy);
                end
            end
            set_ch(chs[k], vals[k]);
            push_coin(vals[k]);
            run_op(ack_v, ack_c, rpt_v, rpt_c, rpt_ovf, ref_v, ref_c, cmp_c, leak);
            e = exp_q.pop_front();
            n_checks++;
            if (rpt_v !== e.val || rpt_ovf !== e.ovf || rpt_c !== 3) begin
                n_fail++; $display("FAIL sat_report%0d: got %0d ovf=%b @%0d expected %0d ovf=%b @3", k, rpt_v, rpt_ovf, rpt_c, e.val, e.ovf);
            end
        end
    endtask

    task automatic test_conflict_abort();
        exp_t e;
        clr = 1'b1; cancel = 1'b1;
        set_ch(0, 7);
        step();
        n_checks++;
        if (in_ack !== '0 || refund !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL conflict_clr_wins: got ack=%b ref=%b busy=%b expected 0000 0 0", in_ack, refund, busy);
        end
        clr = 1'b0; cancel = 1'b0;
        model_clear();
        push_coin(7);
        run_op(ack_v, ack_c, rpt_v, rpt_c, rpt_ovf, ref_v, ref_c, cmp_c, leak);
        e = exp_q.pop_front();
        n_checks++;
        if (ack_v !== 4'b0001 || ack_c !== 1 || rpt_v !== e.val || ref_c !== -1) begin
            n_fail++; $display("FAIL conflict_next: got ack=%b@%0d %0d ref@%0d expected 0001@1 %0d ref@-1", ack_v, ack_c, rpt_v, ref_c, e.val);
        end
        set_ch(2, 9);
        step();
        n_checks++;
        if (in_ack !== 4'b0100) begin
            n_fail++; $display("FAIL abort_ack: got %b expected 0100", in_ack);
        end
        in_rdy = '0;
        step();
        rst = 1'b0;
        step();
        n_checks++;
        if (out_rdy !== 1'b0 || data_out !== '0 || busy !== 1'b0 || in_ack !== '0) begin
            n_fail++; $display("FAIL abort_outputs: got rdy=%b dout=%0d busy=%b ack=%b expected 0 0 0 0000", out_rdy, data_out, busy, in_ack);
        end
        rst = 1'b1;
        step();
        n_checks++;
        if (state_cmp !== 1'b0) begin
            n_fail++; $display("FAIL abort_no_cmp: got %b expected 0", state_cmp);
        end
        model_clear();
        cancel = 1'b1;
        push_refund();
        run_op(ack_v, ack_c, rpt_v, rpt_c, rpt_ovf, ref_v, ref_c, cmp_c, leak);
        e = exp_q.pop_front();
        n_checks++;
        if (ref_v !== e.val || ref_c !== 2 || cmp_c !== 3) begin
            n_fail++; $display("FAIL abort_zero_refund: got %0d@%0d cmp@%0d expected %0d@2 cmp@3", ref_v, ref_c, cmp_c, e.val);
        end
        set_ch(3, 3);
        push_coin(3);
        run_op(ack_v, ack_c, rpt_v, rpt_c, rpt_ovf, ref_v, ref_c, cmp_c, leak);
        e = exp_q.pop_front();
        n_checks++;
        if (ack_v !== 4'b1000 || rpt_v !== e.val || rpt_c !== 3) begin
            n_fail++; $display("FAIL abort_total_cleared: got ack=%b %0d@%0d expected 1000 %0d@3", ack_v, rpt_v, rpt_c, e.val);
        end
    endtask

    initial begin
        rst = 1'b0; clr = 1'b0; cancel = 1'b0; in_rdy = '0; data_in = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_refund();
        test_saturation();
        test_conflict_abort();
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++; $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
